mult_div_unit: RTL

//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage.

---
 rtl/mult_div_unit_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the EX-stage multiply/divide unit.
// Imported by the MDU and by the controller that drives op/start.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'b000,
    MDU_OP_MULTU = 3'b001,
    MDU_OP_DIV   = 3'b010,
    MDU_OP_DIVU  = 3'b011,
    MDU_OP_MTHI  = 3'b100,
    MDU_OP_MTLO  = 3'b101
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Result is computed at start, held pending, and committed when the busy counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] counter;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               div_ovf;

  logic          long_op;
  logic [CW-1:0] load_cycles;
  logic [31:0]   nxt_hi;
  logic [31:0]   nxt_lo;
  logic          nxt_we;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Dividing by 1 instead of 0 or of -1 on INT_MIN keeps the divider defined;
  // for the overflow case it yields exactly LO=0x80000000, HI=0.
  assign div_ovf = (op == MDU_OP_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_b   = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
  assign quo_s   = $signed(A) / $signed(div_b);
  assign rem_s   = $signed(A) % $signed(div_b);
  assign quo_u   = A / div_b;
  assign rem_u   = A % div_b;

  always_comb begin
    long_op     = 1'b0;
    load_cycles = '0;
    nxt_hi      = '0;
    nxt_lo      = '0;
    nxt_we      = 1'b0;
    case (op)
      MDU_OP_MULT: begin
        long_op          = 1'b1;
        load_cycles      = CW'(MULT_CYCLES);
        {nxt_hi, nxt_lo} = prod_s;
        nxt_we           = 1'b1;
      end
      MDU_OP_MULTU: begin
        long_op          = 1'b1;
        load_cycles      = CW'(MULT_CYCLES);
        {nxt_hi, nxt_lo} = prod_u;
        nxt_we           = 1'b1;
      end
      MDU_OP_DIV: begin
        long_op     = 1'b1;
        load_cycles = CW'(DIV_CYCLES);
        nxt_hi      = rem_s;
        nxt_lo      = quo_s;
        nxt_we      = (B != 32'd0);
      end
      MDU_OP_DIVU: begin
        long_op     = 1'b1;
        load_cycles = CW'(DIV_CYCLES);
        nxt_hi      = rem_u;
        nxt_lo      = quo_u;
        nxt_we      = (B != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      busy    <= 1'b0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (counter != '0) begin
      // Starts arriving while busy are dropped; the in-flight op runs to completion.
      counter <= counter - CW'(1);
      busy    <= (counter != CW'(1));
      if ((counter == CW'(1)) && pend_we) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (start) begin
      if (long_op) begin
        counter <= load_cycles;
        busy    <= 1'b1;
        pend_hi <= nxt_hi;
        pend_lo <= nxt_lo;
        pend_we <= nxt_we;
      end else if (op == MDU_OP_MTHI) begin
        HI <= A;
      end else if (op == MDU_OP_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule
